data_mem_responder: RTL

- Multi-cycle data-memory responder: the memory end of the core's load/store interface.
- Accepts one request at a time over a valid/ready handshake and models configurable access latency.
- Performs byte/half/word stores with lane masking; returns sign- or zero-extended loads using RV32I funct3 encoding.
- Replaces the single-cycle data memory once the core moves to a stalling or pipelined datapath.

---
 rtl/data_mem_responder_if.sv | 26 ++
 rtl/data_mem_responder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/data_mem_responder_if.sv
// Load/store bus between the core (master) and the data-memory responder (slave).
interface data_mem_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [2:0]            req_funct3;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_funct3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_funct3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory: one request at a time, configurable latency,
// RV32I byte/half/word loads and stores with lane masking.
module data_mem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input logic                clk,
  input logic                rst,
  data_mem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, ACCESS, RESP} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic                  wr_q;
  logic [IDX_W+1:0]      addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [2:0]            f3_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_error_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic                  err_c;
  logic [3:0]            be_c;
  logic [DATA_WIDTH-1:0] lanes_c;
  logic [DATA_WIDTH-1:0] word_c;
  logic [7:0]            byte_c;
  logic [15:0]           half_c;
  logic [DATA_WIDTH-1:0] load_c;
  logic [IDX_W-1:0]      idx_c;

  assign idx_c         = addr_q[IDX_W+1:2];
  assign word_c        = mem[idx_c];
  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_error = rsp_error_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (LATENCY > 1) state_d = BUSY;
          else             state_d = ACCESS;
        end
      end
      BUSY:   if (cnt_q <= CNT_W'(1)) state_d = ACCESS;
      ACCESS: state_d = RESP;
      RESP:   if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Decode the latched request: error check, store lane enables/data, load extension
  always_comb begin
    err_c   = 1'b0;
    be_c    = '0;
    lanes_c = wdata_q;
    load_c  = '0;
    byte_c  = word_c[{addr_q[1:0], 3'b000} +: 8];
    half_c  = addr_q[1] ? word_c[31:16] : word_c[15:0];
    case (f3_q)
      3'b000, 3'b100: begin
        be_c    = 4'b0001 << addr_q[1:0];
        lanes_c = {4{wdata_q[7:0]}};
      end
      3'b001, 3'b101: begin
        lanes_c = {2{wdata_q[15:0]}};
        if (addr_q[0]) err_c = 1'b1;
        else           be_c  = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      3'b010: begin
        if (addr_q[1:0] != 2'b00) err_c = 1'b1;
        else                      be_c  = 4'b1111;
      end
      default: err_c = 1'b1;
    endcase
    case (f3_q)
      3'b000:  load_c = {{24{byte_c[7]}}, byte_c};
      3'b100:  load_c = {24'h0, byte_c};
      3'b001:  load_c = {{16{half_c[15]}}, half_c};
      3'b101:  load_c = {16'h0, half_c};
      3'b010:  load_c = word_c;
      default: load_c = '0;
    endcase
  end

  // Request latch, latency counter and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      f3_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            wr_q    <= bus.req_write;
            addr_q  <= bus.req_addr[IDX_W+1:0];
            wdata_q <= bus.req_wdata;
            f3_q    <= bus.req_funct3;
            cnt_q   <= CNT_W'(LATENCY - 1);
          end
        end
        BUSY: cnt_q <= cnt_q - CNT_W'(1);
        ACCESS: begin
          rsp_valid_q <= 1'b1;
          rsp_error_q <= err_c;
          rsp_rdata_q <= (wr_q || err_c) ? '0 : load_c;
        end
        RESP: if (bus.rsp_ready) rsp_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // Storage write on the ACCESS edge; reset on that edge cancels the store
  always_ff @(posedge clk) begin
    if (!rst && state_q == ACCESS && wr_q && !err_c) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be_c[i]) mem[idx_c][8*i +: 8] <= lanes_c[8*i +: 8];
      end
    end
  end

endmodule
